// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-mode sequencing controller.
// Holds the FSM encoding, dcsr cause codes and the dcsr field layout.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_STEP  = 3'd1,
        ST_ENTER = 3'd2,
        ST_HALT  = 3'd3,
        ST_EXIT  = 3'd4
    } dbg_state_e;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER   = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

    localparam logic [3:0] XDEBUGVER = 4'd4;

    localparam int DCSR_EBREAKM   = 15;
    localparam int DCSR_EBREAKS   = 13;
    localparam int DCSR_EBREAKU   = 12;
    localparam int DCSR_STOPCYCLE = 10;
    localparam int DCSR_STOPTIME  = 9;
    localparam int DCSR_STEP      = 2;
    localparam int DCSR_PRV_LO    = 0;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    typedef struct packed {
        logic [3:0]  xdebugver;
        logic [11:0] rsvd_27_16;
        logic        ebreakm;
        logic        ebreakh;
        logic        ebreaks;
        logic        ebreaku;
        logic        rsvd_11;
        logic        stopcycle;
        logic        stoptime;
        logic [2:0]  cause;
        logic [2:0]  rsvd_5_3;
        logic        step;
        logic [1:0]  prv;
    } dcsr_t;

    // WARL filter: only privilege levels that exist may be restored.
    function automatic logic prv_legal(
        input logic [1:0] p,
        input logic       has_s,
        input logic       has_u
    );
        return (p == PRV_M) ||
               ((p == PRV_S) && has_s) ||
               ((p == PRV_U) && has_u);
    endfunction

endpackage

// File: rtl/debug_cause_arb.sv
// Priority encoder choosing which debug-entry cause wins this cycle.
// Produces CAUSE_NONE and no enter flag when the hart is not running.
module debug_cause_arb
    import debug_pkg::*;
(
    input  logic       i_active,
    input  logic       i_in_step,
    input  logic       i_trigger,
    input  logic       i_ebreak,
    input  logic       i_haltreq,
    input  logic       i_step_done,
    input  logic       i_resethalt,
    output logic       o_enter,
    output logic [2:0] o_cause
);

    always_comb begin
        o_cause = CAUSE_NONE;
        if (i_active) begin
            if (i_trigger) begin
                o_cause = CAUSE_TRIGGER;
            end else if (i_ebreak) begin
                o_cause = CAUSE_EBREAK;
            end else if (i_haltreq) begin
                o_cause = CAUSE_HALTREQ;
            end else if (i_in_step && i_step_done) begin
                o_cause = CAUSE_STEP;
            end else if (i_resethalt) begin
                o_cause = CAUSE_RESETHALT;
            end
        end
    end

    assign o_enter = (o_cause != CAUSE_NONE);

endmodule

// File: rtl/debug_mode_ctrl.sv
// Debug Mode entry/exit sequencer owning the dcsr fields.
// Bridges Debug Module halt/resume requests and core retire/redirect.
module debug_mode_ctrl
    import debug_pkg::*;
#(
    parameter bit HAS_S = 1'b0,
    parameter bit HAS_U = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        resethaltreq,
    input  logic        haltreq,
    input  logic        resumereq,
    input  logic        retire_valid,
    input  logic        trap_valid,
    input  logic        ebreak_valid,
    input  logic        trigger_hit,
    input  logic [1:0]  cur_prv,
    input  logic        csr_wr_en,
    input  logic [31:0] csr_wdata,
    output logic [31:0] dcsr_rdata,
    output logic        debug_mode,
    output logic        halted,
    output logic        resumeack,
    output logic        dpc_capture,
    output logic        redirect_dpc,
    output logic [1:0]  restore_prv,
    output logic        ebreak_to_debug,
    output logic        stop_count,
    output logic        stop_time,
    output logic        step_irq_mask
);

    dbg_state_e r_state;
    dbg_state_e w_next_state;

    logic       r_first;
    logic       r_ebm;
    logic       r_ebs;
    logic       r_ebu;
    logic       r_sc;
    logic       r_st;
    logic       r_step;
    logic [1:0] r_prv;
    logic [2:0] r_cause;

    logic       w_in_step;
    logic       w_active;
    logic       w_step_done;
    logic       w_enter;
    logic [2:0] w_cause;
    logic       w_wr;
    logic       w_resume;
    logic       w_dm;
    logic       w_ebreak_en;
    logic       w_unused;
    dcsr_t      w_dcsr;

    assign w_in_step   = (r_state == ST_STEP);
    assign w_active    = (r_state == ST_RUN) | w_in_step;
    assign w_step_done = retire_valid | trap_valid;
    assign w_wr        = (r_state == ST_HALT) & csr_wr_en;
    assign w_resume    = (r_state == ST_HALT) & resumereq & ~haltreq;
    assign w_dm        = (r_state == ST_ENTER) |
                         (r_state == ST_HALT)  |
                         (r_state == ST_EXIT);

    always_comb begin
        w_ebreak_en = 1'b0;
        unique case (cur_prv)
            PRV_M:   w_ebreak_en = r_ebm;
            PRV_S:   w_ebreak_en = r_ebs;
            PRV_U:   w_ebreak_en = r_ebu;
            default: w_ebreak_en = 1'b0;
        endcase
    end

    assign ebreak_to_debug = ebreak_valid & w_ebreak_en;

    debug_cause_arb u_arb (
        .i_active    (w_active),
        .i_in_step   (w_in_step),
        .i_trigger   (trigger_hit),
        .i_ebreak    (ebreak_to_debug),
        .i_haltreq   (haltreq),
        .i_step_done (w_step_done),
        .i_resethalt (r_first & resethaltreq),
        .o_enter     (w_enter),
        .o_cause     (w_cause)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN, ST_STEP: begin
                if (w_enter) begin
                    w_next_state = ST_ENTER;
                end
            end
            ST_ENTER: w_next_state = ST_HALT;
            ST_HALT: begin
                if (w_resume) begin
                    w_next_state = ST_EXIT;
                end
            end
            // r_step already holds any write made alongside resumereq
            ST_EXIT:  w_next_state = r_step ? ST_STEP : ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_first <= 1'b1;
            r_ebm   <= 1'b0;
            r_ebs   <= 1'b0;
            r_ebu   <= 1'b0;
            r_sc    <= 1'b0;
            r_st    <= 1'b0;
            r_step  <= 1'b0;
            r_prv   <= PRV_M;
            r_cause <= CAUSE_NONE;
        end else begin
            r_first <= 1'b0;
            if (w_enter) begin
                r_cause <= w_cause;
                r_prv   <= cur_prv;
            end
            if (w_wr) begin
                r_ebm  <= csr_wdata[DCSR_EBREAKM];
                r_sc   <= csr_wdata[DCSR_STOPCYCLE];
                r_st   <= csr_wdata[DCSR_STOPTIME];
                r_step <= csr_wdata[DCSR_STEP];
                if (HAS_S) begin
                    r_ebs <= csr_wdata[DCSR_EBREAKS];
                end
                if (HAS_U) begin
                    r_ebu <= csr_wdata[DCSR_EBREAKU];
                end
                if (prv_legal(csr_wdata[DCSR_PRV_LO +: 2], HAS_S, HAS_U)) begin
                    r_prv <= csr_wdata[DCSR_PRV_LO +: 2];
                end
            end
        end
    end

    always_comb begin
        w_dcsr           = '0;
        w_dcsr.xdebugver = XDEBUGVER;
        w_dcsr.ebreakm   = r_ebm;
        w_dcsr.ebreakh   = 1'b0;
        w_dcsr.ebreaks   = r_ebs;
        w_dcsr.ebreaku   = r_ebu;
        w_dcsr.stopcycle = r_sc;
        w_dcsr.stoptime  = r_st;
        w_dcsr.cause     = r_cause;
        w_dcsr.step      = r_step;
        w_dcsr.prv       = r_prv;
    end

    assign w_unused = ^{csr_wdata[31:16], csr_wdata[14],
                        csr_wdata[11], csr_wdata[8:3]};

    assign dcsr_rdata    = w_dcsr;
    assign debug_mode    = w_dm;
    assign halted        = (r_state == ST_HALT);
    assign dpc_capture   = (r_state == ST_ENTER);
    assign resumeack     = (r_state == ST_EXIT);
    assign redirect_dpc  = (r_state == ST_EXIT);
    assign restore_prv   = (r_state == ST_EXIT) ? r_prv : 2'b00;
    assign stop_count    = w_dm & r_sc;
    assign stop_time     = w_dm & r_st;
    assign step_irq_mask = r_step & ~w_dm;

endmodule

// File: tb/tb_debug_mode_ctrl.sv
// Scoreboard bench for debug_mode_ctrl: directed scenarios then random traffic.
// Expected outputs come from a behavioural model of the debug sequencing rules.
module tb_debug_mode_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        resethaltreq;
    logic        haltreq;
    logic        resumereq;
    logic        retire_valid;
    logic        trap_valid;
    logic        ebreak_valid;
    logic        trigger_hit;
    logic [1:0]  cur_prv;
    logic        csr_wr_en;
    logic [31:0] csr_wdata;
    logic [31:0] dcsr_rdata;
    logic        debug_mode;
    logic        halted;
    logic        resumeack;
    logic        dpc_capture;
    logic        redirect_dpc;
    logic [1:0]  restore_prv;
    logic        ebreak_to_debug;
    logic        stop_count;
    logic        stop_time;
    logic        step_irq_mask;

    always #5 clock = ~clock;

    debug_mode_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .resethaltreq    (resethaltreq),
        .haltreq         (haltreq),
        .resumereq       (resumereq),
        .retire_valid    (retire_valid),
        .trap_valid      (trap_valid),
        .ebreak_valid    (ebreak_valid),
        .trigger_hit     (trigger_hit),
        .cur_prv         (cur_prv),
        .csr_wr_en       (csr_wr_en),
        .csr_wdata       (csr_wdata),
        .dcsr_rdata      (dcsr_rdata),
        .debug_mode      (debug_mode),
        .halted          (halted),
        .resumeack       (resumeack),
        .dpc_capture     (dpc_capture),
        .redirect_dpc    (redirect_dpc),
        .restore_prv     (restore_prv),
        .ebreak_to_debug (ebreak_to_debug),
        .stop_count      (stop_count),
        .stop_time       (stop_time),
        .step_irq_mask   (step_irq_mask)
    );

    typedef struct packed {
        logic [31:0] dcsr;
        logic        dm;
        logic        halted;
        logic        ack;
        logic        cap;
        logic        redir;
        logic [1:0]  rprv;
        logic        e2d;
        logic        sc;
        logic        st;
        logic        irq;
    } out_t;

    out_t q[$];
    out_t w_act;
    int   checks = 0;
    int   errors = 0;

    assign w_act = {dcsr_rdata, debug_mode, halted, resumeack, dpc_capture,
                    redirect_dpc, restore_prv, ebreak_to_debug, stop_count,
                    stop_time, step_irq_mask};

    // Model: mode names, dcsr fields as plain bits.
    localparam int M_RUN = 0, M_STEP = 1, M_ENTER = 2, M_HALT = 3, M_EXIT = 4;
    localparam bit HS = 1'b0;
    localparam bit HU = 1'b1;

    int       m_mode;
    bit       m_ebm, m_ebs, m_ebu, m_sc, m_st, m_step, m_first;
    bit [1:0] m_prv;
    bit [2:0] m_cause;

    task automatic model_reset();
        m_mode = M_RUN;
        m_ebm = 0; m_ebs = 0; m_ebu = 0; m_sc = 0; m_st = 0; m_step = 0;
        m_prv = 2'd3; m_cause = 3'd0; m_first = 1;
    endtask

    function automatic bit model_e2d();
        if (!ebreak_valid) return 0;
        if (cur_prv == 2'd3) return m_ebm;
        if (cur_prv == 2'd1) return m_ebs;
        if (cur_prv == 2'd0) return m_ebu;
        return 0;
    endfunction

    function automatic out_t model_out();
        out_t o;
        bit dm;
        dm = (m_mode == M_ENTER) || (m_mode == M_HALT) || (m_mode == M_EXIT);
        o.dcsr = (32'd4 << 28) + (32'(m_ebm) << 15) + (32'(m_ebs) << 13)
               + (32'(m_ebu) << 12) + (32'(m_sc) << 10) + (32'(m_st) << 9)
               + (32'(m_cause) << 6) + (32'(m_step) << 2) + 32'(m_prv);
        o.dm     = dm;
        o.halted = (m_mode == M_HALT);
        o.ack    = (m_mode == M_EXIT);
        o.cap    = (m_mode == M_ENTER);
        o.redir  = (m_mode == M_EXIT);
        o.rprv   = (m_mode == M_EXIT) ? m_prv : 2'd0;
        o.e2d    = model_e2d();
        o.sc     = dm && m_sc;
        o.st     = dm && m_st;
        o.irq    = m_step && !dm;
        return o;
    endfunction

    task automatic model_advance();
        int c;
        bit [1:0] p;
        c = 0;
        case (m_mode)
            M_RUN, M_STEP: begin
                if (trigger_hit) c = 2;
                else if (model_e2d()) c = 1;
                else if (haltreq) c = 3;
                else if (m_mode == M_STEP && (retire_valid || trap_valid)) c = 4;
                else if (m_first && resethaltreq) c = 5;
                if (c != 0) begin
                    m_cause = 3'(c);
                    m_prv = cur_prv;
                    m_mode = M_ENTER;
                end
            end
            M_ENTER: m_mode = M_HALT;
            M_HALT: begin
                if (csr_wr_en) begin
                    m_ebm = csr_wdata[15];
                    if (HS) m_ebs = csr_wdata[13];
                    if (HU) m_ebu = csr_wdata[12];
                    m_sc = csr_wdata[10];
                    m_st = csr_wdata[9];
                    m_step = csr_wdata[2];
                    p = csr_wdata[1:0];
                    if (p == 3 || (p == 1 && HS) || (p == 0 && HU)) m_prv = p;
                end
                if (resumereq && !haltreq) m_mode = M_EXIT;
            end
            default: m_mode = m_step ? M_STEP : M_RUN;
        endcase
        m_first = 0;
    endtask

    // Called at posedge+1 once this cycle's inputs are applied.
    task automatic drive_cycle();
        if (!reset_n) model_reset();
        q.push_back(model_out());
        if (reset_n) model_advance();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        resumereq = 0; retire_valid = 0; trap_valid = 0; ebreak_valid = 0;
        trigger_hit = 0; csr_wr_en = 0; csr_wdata = '0; resethaltreq = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            out_t e;
            e = q.pop_front();
            checks++;
            if (w_act !== e) begin
                errors++;
                $display("FAIL sb @%0t got %h expected %h", $time, w_act, e);
            end
        end
    end

    initial begin
        reset_n = 0; haltreq = 0; cur_prv = 2'd3;
        clr();
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_dcsr", dcsr_rdata, 32'h4000_0003);
        repeat (2) drive_cycle();
        reset_n = 1;
        repeat (9) drive_cycle();

        // haltreq from RUN
        haltreq = 1;
        drive_cycle();
        haltreq = 0;
        chk("t1_cap", 32'(dpc_capture), 32'd1);
        drive_cycle();
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_cause", 32'(dcsr_rdata[8:6]), 32'd3);
        chk("t1_ver", 32'(dcsr_rdata[31:28]), 32'd4);

        // enable ebreakm, resume, ebreak in M-mode
        csr_wr_en = 1; csr_wdata = 32'h0000_8003; resumereq = 1;
        drive_cycle();
        clr();
        chk("t2_ack", {resumeack, redirect_dpc, restore_prv}, 32'hF);
        drive_cycle();
        ebreak_valid = 1; cur_prv = 2'd3;
        #1;
        chk("t2_e2d", 32'(ebreak_to_debug), 32'd1);
        drive_cycle();
        clr();
        drive_cycle();
        chk("t2_cause", 32'(dcsr_rdata[8:6]), 32'd1);
        chk("t2_prv", 32'(dcsr_rdata[1:0]), 32'd3);

        // single-step
        csr_wr_en = 1; csr_wdata = 32'h0000_8007; resumereq = 1;
        drive_cycle();
        clr();
        chk("t3_ack", 32'(resumeack), 32'd1);
        drive_cycle();
        chk("t3_irqmask", 32'(step_irq_mask), 32'd1);
        retire_valid = 1;
        drive_cycle();
        clr();
        drive_cycle();
        chk("t3_cause_step", 32'(dcsr_rdata[8:6]), 32'd4);
        resumereq = 1;
        drive_cycle();
        clr();
        drive_cycle();
        retire_valid = 1; trigger_hit = 1;
        drive_cycle();
        clr();
        drive_cycle();
        chk("t3_cause_trig", 32'(dcsr_rdata[8:6]), 32'd2);

        // WARL prv and absent S-mode
        csr_wr_en = 1; csr_wdata = 32'h0000_2002;
        drive_cycle();
        clr();
        chk("t4_prv", 32'(dcsr_rdata[1:0]), 32'd3);
        chk("t4_ebreaks", 32'(dcsr_rdata[13]), 32'd0);

        // stopcycle
        resumereq = 1;
        drive_cycle();
        clr();
        drive_cycle();
        csr_wr_en = 1; csr_wdata = 32'h0000_0400;
        drive_cycle();
        clr();
        chk("t5_run_wr", 32'(dcsr_rdata[10]), 32'd0);
        haltreq = 1;
        drive_cycle();
        haltreq = 0;
        drive_cycle();
        csr_wr_en = 1; csr_wdata = 32'h0000_0403;
        drive_cycle();
        clr();
        chk("t5_stop_halt", 32'(stop_count), 32'd1);
        resumereq = 1;
        drive_cycle();
        clr();
        drive_cycle();
        chk("t5_stop_run", 32'(stop_count), 32'd0);
        chk("t5_sc_bit", 32'(dcsr_rdata[10]), 32'd1);

        // reset during ENTER, then reset-halt
        haltreq = 1;
        drive_cycle();
        haltreq = 0;
        chk("t6_cap", 32'(dpc_capture), 32'd1);
        reset_n = 0;
        #1;
        chk("t6_cap_drop", 32'(dpc_capture), 32'd0);
        chk("t6_dcsr", dcsr_rdata, 32'h4000_0003);
        drive_cycle();
        reset_n = 1; resethaltreq = 1;
        drive_cycle();
        resethaltreq = 0;
        chk("t6_rh_cap", 32'(dpc_capture), 32'd1);
        drive_cycle();
        chk("t6_rh_halted", 32'(halted), 32'd1);
        chk("t6_rh_cause", 32'(dcsr_rdata[8:6]), 32'd5);
        resumereq = 1;
        drive_cycle();
        clr();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) haltreq = ~haltreq;
            resumereq    = ($urandom_range(0, 3) == 0);
            retire_valid = ($urandom_range(0, 1) == 0);
            trap_valid   = ($urandom_range(0, 15) == 0);
            ebreak_valid = ($urandom_range(0, 7) == 0);
            trigger_hit  = ($urandom_range(0, 15) == 0);
            cur_prv      = 2'($urandom_range(0, 3));
            csr_wr_en    = ($urandom_range(0, 3) == 0);
            csr_wdata    = $urandom;
            resethaltreq = ($urandom_range(0, 1) == 0);
            if (!reset_n) reset_n = 1;
            else if ($urandom_range(0, 399) == 0) reset_n = 0;
            drive_cycle();
        end
        clr();
        haltreq = 0;
        reset_n = 1;

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
